// File: rtl/elgamal_session_ctrl.sv
// Session sequencer for encrypting_entity: loads p/key once, then runs one message at a time and merges a/b.
// Optional COLLECT watchdog enabled by defining ELGAMAL_TIMEOUT_EN.
// state    | meaning
// IDLE     | no valid key, waiting for config
// LOAD     | presenting p and key to the entity for one cycle
// WAIT_MSG | key loaded, ready for a message or a new config
// ISSUE    | presenting m to the entity for one cycle
// COLLECT  | waiting for both a and b from the entity
// EMIT     | holding {a,b} until downstream accepts
module elgamal_session_ctrl #(
    parameter int SIZE    = 64,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   cfg_p_tdata,
    input  logic              cfg_p_tvalid,
    input  logic [SIZE-1:0]   cfg_key_tdata,
    input  logic              cfg_key_tvalid,
    output logic              cfg_tready,
    input  logic [SIZE-1:0]   s_m_tdata,
    input  logic              s_m_tvalid,
    output logic              s_m_tready,
    output logic [SIZE-1:0]   ee_p_tdata,
    output logic              ee_p_tvalid,
    output logic [SIZE-1:0]   ee_a_key_tdata,
    output logic              ee_a_key_tvalid,
    output logic [SIZE-1:0]   ee_m_tdata,
    output logic              ee_m_tvalid,
    input  logic [SIZE-1:0]   ee_a_tdata,
    input  logic              ee_a_tvalid,
    output logic              ee_a_tready,
    input  logic [SIZE-1:0]   ee_b_tdata,
    input  logic              ee_b_tvalid,
    output logic              ee_b_tready,
    output logic [2*SIZE-1:0] m_res_tdata,
    output logic              m_res_tvalid,
    input  logic              m_res_tready,
    output logic              busy,
    output logic [CNT_W-1:0]  msg_count,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_MSG, S_ISSUE, S_COLLECT, S_EMIT
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   p_q, p_d, key_q, key_d, m_q, m_d, a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cfg_rdy_q, cfg_rdy_d, m_rdy_q, m_rdy_d;
    logic              ld_vld_q, ld_vld_d, iss_vld_q, iss_vld_d;
    logic              a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
    logic              res_vld_q, res_vld_d, busy_q, busy_d;
    logic              cfg_both, cfg_fire, msg_fire, res_fire;
    logic              a_cap, b_cap, a_have, b_have;

`ifdef ELGAMAL_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
`endif

    assign cfg_both = cfg_p_tvalid & cfg_key_tvalid;
    assign cfg_fire = cfg_both & cfg_rdy_q;
    // A simultaneous config wins, so the message must not see ready that cycle.
    assign s_m_tready = m_rdy_q & ~cfg_both;
    assign msg_fire = s_m_tvalid & s_m_tready;
    assign res_fire = res_vld_q & m_res_tready;
    assign a_cap    = a_rdy_q & ee_a_tvalid;
    assign b_cap    = b_rdy_q & ee_b_tvalid;
    assign a_have   = (state_q == S_COLLECT) & (~a_rdy_q | a_cap);
    assign b_have   = (state_q == S_COLLECT) & (~b_rdy_q | b_cap);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        key_d   = key_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
`ifdef ELGAMAL_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_WAIT_MSG: begin
                if (cfg_fire) begin
                    p_d     = cfg_p_tdata;
                    key_d   = cfg_key_tdata;
                    cnt_d   = '0;
`ifdef ELGAMAL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_LOAD;
                end else if (msg_fire) begin
                    m_d     = s_m_tdata;
                    state_d = S_ISSUE;
                end
            end
            S_LOAD:  state_d = S_WAIT_MSG;
            S_ISSUE: begin
`ifdef ELGAMAL_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (a_cap) a_d = ee_a_tdata;
                if (b_cap) b_d = ee_b_tdata;
                if (a_have && b_have) begin
                    state_d = S_EMIT;
                end
`ifdef ELGAMAL_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            S_EMIT: begin
                if (res_fire) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_WAIT_MSG;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs are registered, so they follow the next state.
        cfg_rdy_d = (state_d == S_IDLE) || (state_d == S_WAIT_MSG);
        m_rdy_d   = (state_d == S_WAIT_MSG);
        ld_vld_d  = (state_d == S_LOAD);
        iss_vld_d = (state_d == S_ISSUE);
        a_rdy_d   = (state_d == S_COLLECT) && !a_have;
        b_rdy_d   = (state_d == S_COLLECT) && !b_have;
        res_vld_d = (state_d == S_EMIT);
        busy_d    = !cfg_rdy_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            p_q       <= '0;
            key_q     <= '0;
            m_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            cfg_rdy_q <= 1'b0;
            m_rdy_q   <= 1'b0;
            ld_vld_q  <= 1'b0;
            iss_vld_q <= 1'b0;
            a_rdy_q   <= 1'b0;
            b_rdy_q   <= 1'b0;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ELGAMAL_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            key_q     <= key_d;
            m_q       <= m_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            cfg_rdy_q <= cfg_rdy_d;
            m_rdy_q   <= m_rdy_d;
            ld_vld_q  <= ld_vld_d;
            iss_vld_q <= iss_vld_d;
            a_rdy_q   <= a_rdy_d;
            b_rdy_q   <= b_rdy_d;
            res_vld_q <= res_vld_d;
            busy_q    <= busy_d;
`ifdef ELGAMAL_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    assign cfg_tready      = cfg_rdy_q;
    assign ee_p_tdata      = p_q;
    assign ee_p_tvalid     = ld_vld_q;
    assign ee_a_key_tdata  = key_q;
    assign ee_a_key_tvalid = ld_vld_q;
    assign ee_m_tdata      = m_q;
    assign ee_m_tvalid     = iss_vld_q;
    assign ee_a_tready     = a_rdy_q;
    assign ee_b_tready     = b_rdy_q;
    assign m_res_tdata     = {a_q, b_q};
    assign m_res_tvalid    = res_vld_q;
    assign busy            = busy_q;
    assign msg_count       = cnt_q;
`ifdef ELGAMAL_TIMEOUT_EN
    assign timeout_err     = err_q;
`else
    assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_elgamal_session_ctrl.sv
// Directed bench for elgamal_session_ctrl with a delayed-response entity stub (a=m^1, b=m+7).
module tb_elgamal_session_ctrl;
    localparam int SIZE = 64;
    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [SIZE-1:0]   cfg_p_tdata, cfg_key_tdata, s_m_tdata;
    logic              cfg_p_tvalid, cfg_key_tvalid, cfg_tready;
    logic              s_m_tvalid, s_m_tready;
    logic [SIZE-1:0]   ee_p_tdata, ee_a_key_tdata, ee_m_tdata;
    logic              ee_p_tvalid, ee_a_key_tvalid, ee_m_tvalid;
    logic [SIZE-1:0]   ee_a_tdata, ee_b_tdata;
    logic              ee_a_tvalid, ee_b_tvalid, ee_a_tready, ee_b_tready;
    logic [2*SIZE-1:0] m_res_tdata;
    logic              m_res_tvalid, m_res_tready, busy, timeout_err;
    logic [CNT_W-1:0]  msg_count;

    int checks = 0;
    int failures = 0;

    // Entity stub state
    logic [SIZE-1:0] stub_m;
    int dly_a = 3, dly_b = 5, a_cd, b_cd;
    logic stub_mute = 1'b0;

    elgamal_session_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_p_tdata(cfg_p_tdata), .cfg_p_tvalid(cfg_p_tvalid),
        .cfg_key_tdata(cfg_key_tdata), .cfg_key_tvalid(cfg_key_tvalid),
        .cfg_tready(cfg_tready),
        .s_m_tdata(s_m_tdata), .s_m_tvalid(s_m_tvalid), .s_m_tready(s_m_tready),
        .ee_p_tdata(ee_p_tdata), .ee_p_tvalid(ee_p_tvalid),
        .ee_a_key_tdata(ee_a_key_tdata), .ee_a_key_tvalid(ee_a_key_tvalid),
        .ee_m_tdata(ee_m_tdata), .ee_m_tvalid(ee_m_tvalid),
        .ee_a_tdata(ee_a_tdata), .ee_a_tvalid(ee_a_tvalid), .ee_a_tready(ee_a_tready),
        .ee_b_tdata(ee_b_tdata), .ee_b_tvalid(ee_b_tvalid), .ee_b_tready(ee_b_tready),
        .m_res_tdata(m_res_tdata), .m_res_tvalid(m_res_tvalid), .m_res_tready(m_res_tready),
        .busy(busy), .msg_count(msg_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign ee_a_tdata = stub_m ^ 64'd1;
    assign ee_b_tdata = stub_m + 64'd7;

    always @(posedge clk) begin
        if (!rst) begin
            ee_a_tvalid <= 1'b0;
            ee_b_tvalid <= 1'b0;
            a_cd <= 0;
            b_cd <= 0;
            stub_m <= '0;
        end else begin
            if (ee_m_tvalid && !stub_mute) begin
                stub_m <= ee_m_tdata;
                a_cd <= dly_a;
                b_cd <= dly_b;
            end else begin
                if (a_cd != 0) begin
                    a_cd <= a_cd - 1;
                    if (a_cd == 1) ee_a_tvalid <= 1'b1;
                end
                if (b_cd != 0) begin
                    b_cd <= b_cd - 1;
                    if (b_cd == 1) ee_b_tvalid <= 1'b1;
                end
            end
            if (ee_a_tvalid && ee_a_tready) ee_a_tvalid <= 1'b0;
            if (ee_b_tvalid && ee_b_tready) ee_b_tvalid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input int max, input string tag);
        int n = 0;
        while (!m_res_tvalid && n < max) begin
            tick();
            n++;
        end
        chk(tag, 128'(m_res_tvalid), 128'd1);
    endtask

    task automatic send_msg(input logic [SIZE-1:0] m);
        s_m_tdata = m;
        s_m_tvalid = 1'b1;
        tick();
        s_m_tvalid = 1'b0;
    endtask

    localparam logic [SIZE-1:0] P1   = 64'd18446744073709551337;
    localparam logic [SIZE-1:0] K1   = 64'd1276454389566241996;
    localparam logic [SIZE-1:0] M1   = 64'd98154719832413245;
    localparam logic [SIZE-1:0] P2   = 64'h00000000_0000_0FFB;
    localparam logic [SIZE-1:0] K2   = 64'h00000000_0000_0123;

    initial begin
        rst = 1'b0;
        cfg_p_tdata = '0; cfg_key_tdata = '0; cfg_p_tvalid = 1'b0; cfg_key_tvalid = 1'b0;
        s_m_tdata = '0; s_m_tvalid = 1'b0; m_res_tready = 1'b1;
        tick(); tick();
        chk("rst_cfg_tready", 128'(cfg_tready), 128'd0);
        chk("rst_s_m_tready", 128'(s_m_tready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_msg_count", 128'(msg_count), 128'd0);
        chk("rst_res_tvalid", 128'(m_res_tvalid), 128'd0);
        chk("rst_ee_p_tvalid", 128'(ee_p_tvalid), 128'd0);
        rst = 1'b1;
        tick();
        chk("idle_cfg_tready", 128'(cfg_tready), 128'd1);

        // 1: config load
        cfg_p_tdata = P1; cfg_key_tdata = K1; cfg_p_tvalid = 1'b1; cfg_key_tvalid = 1'b1;
        tick();
        cfg_p_tvalid = 1'b0; cfg_key_tvalid = 1'b0;
        chk("load_p_tvalid", 128'(ee_p_tvalid), 128'd1);
        chk("load_key_tvalid", 128'(ee_a_key_tvalid), 128'd1);
        chk("load_p_tdata", 128'(ee_p_tdata), 128'(P1));
        chk("load_key_tdata", 128'(ee_a_key_tdata), 128'(K1));
        chk("load_busy", 128'(busy), 128'd1);
        chk("load_cfg_tready", 128'(cfg_tready), 128'd0);
        tick();
        chk("wait_p_tvalid", 128'(ee_p_tvalid), 128'd0);
        chk("wait_key_tvalid", 128'(ee_a_key_tvalid), 128'd0);
        chk("wait_busy", 128'(busy), 128'd0);
        chk("wait_s_m_tready", 128'(s_m_tready), 128'd1);

        // 2: a after 3 cycles, b after 5
        dly_a = 3; dly_b = 5;
        send_msg(M1);
        chk("issue_m_tvalid", 128'(ee_m_tvalid), 128'd1);
        chk("issue_m_tdata", 128'(ee_m_tdata), 128'(M1));
        chk("issue_s_m_tready", 128'(s_m_tready), 128'd0);
        chk("issue_p_tvalid", 128'(ee_p_tvalid), 128'd0);
        repeat (5) tick();
        chk("t2_a_tready_after_cap", 128'(ee_a_tready), 128'd0);
        chk("t2_b_tready_pending", 128'(ee_b_tready), 128'd1);
        tick();
        chk("t2_no_res_yet", 128'(m_res_tvalid), 128'd0);
        tick();
        chk("t2_res_tvalid", 128'(m_res_tvalid), 128'd1);
        chk("t2_res_tdata", m_res_tdata, {64'd98154719832413244, 64'd98154719832413252});
        chk("t2_a_tready_emit", 128'(ee_a_tready), 128'd0);
        tick();
        chk("t2_res_done", 128'(m_res_tvalid), 128'd0);
        chk("t2_msg_count", 128'(msg_count), 128'd1);

        // 3a: a and b together
        dly_a = 2; dly_b = 2;
        send_msg(64'h0123456789ABCDEF);
        wait_res(20, "t3a_res_timeout");
        chk("t3a_res_tdata", m_res_tdata, {64'h0123456789ABCDEE, 64'h0123456789ABCDF6});
        chk("t3a_b_tready_emit", 128'(ee_b_tready), 128'd0);
        tick();
        chk("t3a_msg_count", 128'(msg_count), 128'd2);

        // 3b: b before a, b wraps
        dly_a = 6; dly_b = 2;
        send_msg(64'hFFFFFFFFFFFFFFFC);
        wait_res(20, "t3b_res_timeout");
        chk("t3b_res_tdata", m_res_tdata, {64'hFFFFFFFFFFFFFFFD, 64'h0000000000000003});
        tick();
        chk("t3b_single_result", 128'(m_res_tvalid), 128'd0);
        chk("t3b_msg_count", 128'(msg_count), 128'd3);

        // 4: downstream backpressure
        m_res_tready = 1'b0;
        dly_a = 3; dly_b = 1;
        send_msg(64'd1000);
        wait_res(20, "t4_res_timeout");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_tvalid", 128'(m_res_tvalid), 128'd1);
            chk("t4_hold_tdata", m_res_tdata, {64'd1001, 64'd1007});
            chk("t4_hold_s_m_tready", 128'(s_m_tready), 128'd0);
            chk("t4_hold_count", 128'(msg_count), 128'd3);
        end
        m_res_tready = 1'b1;
        tick();
        chk("t4_msg_count", 128'(msg_count), 128'd4);
        chk("t4_res_done", 128'(m_res_tvalid), 128'd0);

        // 5: config and message collide in WAIT_MSG
        cfg_p_tdata = P2; cfg_key_tdata = K2; cfg_p_tvalid = 1'b1; cfg_key_tvalid = 1'b1;
        s_m_tdata = 64'd55; s_m_tvalid = 1'b1;
        #1;
        chk("t5_s_m_tready_blocked", 128'(s_m_tready), 128'd0);
        chk("t5_cfg_tready", 128'(cfg_tready), 128'd1);
        tick();
        cfg_p_tvalid = 1'b0; cfg_key_tvalid = 1'b0;
        chk("t5_load_p", 128'(ee_p_tdata), 128'(P2));
        chk("t5_load_key", 128'(ee_a_key_tdata), 128'(K2));
        chk("t5_load_p_tvalid", 128'(ee_p_tvalid), 128'd1);
        chk("t5_count_cleared", 128'(msg_count), 128'd0);
        chk("t5_no_issue", 128'(ee_m_tvalid), 128'd0);
        tick();
        chk("t5_wait_ready", 128'(s_m_tready), 128'd1);
        tick();
        s_m_tvalid = 1'b0;
        chk("t5_issue_tvalid", 128'(ee_m_tvalid), 128'd1);
        chk("t5_issue_tdata", 128'(ee_m_tdata), 128'd55);
        wait_res(20, "t5_res_timeout");
        chk("t5_res_tdata", m_res_tdata, {64'd54, 64'd62});
        tick();
        chk("t5_msg_count", 128'(msg_count), 128'd1);

        // 6: reset during COLLECT
        dly_a = 10; dly_b = 10;
        send_msg(64'd77);
        repeat (3) tick();
        chk("t6_in_collect", 128'(ee_a_tready), 128'd1);
        rst = 1'b0;
        tick();
        chk("t6_rst_a_tready", 128'(ee_a_tready), 128'd0);
        chk("t6_rst_b_tready", 128'(ee_b_tready), 128'd0);
        chk("t6_rst_res_tvalid", 128'(m_res_tvalid), 128'd0);
        chk("t6_rst_m_tvalid", 128'(ee_m_tvalid), 128'd0);
        chk("t6_rst_count", 128'(msg_count), 128'd0);
        chk("t6_rst_busy", 128'(busy), 128'd0);
        rst = 1'b1;
        tick();
        chk("t6_idle_cfg_tready", 128'(cfg_tready), 128'd1);
        repeat (12) tick();
        chk("t6_no_partial_result", 128'(m_res_tvalid), 128'd0);
        chk("t6_no_msg_ready", 128'(s_m_tready), 128'd0);

`ifdef ELGAMAL_TIMEOUT_EN
        cfg_p_tdata = P1; cfg_key_tdata = K1; cfg_p_tvalid = 1'b1; cfg_key_tvalid = 1'b1;
        tick();
        cfg_p_tvalid = 1'b0; cfg_key_tvalid = 1'b0;
        tick();
        stub_mute = 1'b1;
        send_msg(64'd9);
        tick();
        repeat (15) tick();
        chk("to_not_yet", 128'(timeout_err), 128'd0);
        chk("to_busy_collect", 128'(busy), 128'd1);
        tick();
        chk("to_err_set", 128'(timeout_err), 128'd1);
        chk("to_idle_cfg_tready", 128'(cfg_tready), 128'd1);
        chk("to_idle_busy", 128'(busy), 128'd0);
        chk("to_no_msg_ready", 128'(s_m_tready), 128'd0);
        stub_mute = 1'b0;
        cfg_p_tvalid = 1'b1; cfg_key_tvalid = 1'b1;
        tick();
        cfg_p_tvalid = 1'b0; cfg_key_tvalid = 1'b0;
        chk("to_err_cleared", 128'(timeout_err), 128'd0);
`else
        chk("timeout_err_tied", 128'(timeout_err), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
